// File: rtl/mix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mix_sequencer
// Purpose  : Time-multiplexed 8-channel audio mix through one shared adder.
//            Define MIXER_AVG_EN to output sum/8 instead of the full sum.
// Revision : 1.0 - initial release
// ============================================================================
module mix_sequencer #(
    parameter int SAMPLE_DIV = 1134,
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_W   = 8
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] audio_bus,
    input  logic [NUM_CH-1:0]          ch_enable,
    output logic [10:0]                mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int c_cnt_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_idx_w = $clog2(NUM_CH);
    localparam int c_mix_w = 11;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_CH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [c_cnt_w-1:0]         r_cnt;
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [NUM_CH*SAMPLE_W-1:0] r_snap;
    logic [NUM_CH-1:0]          r_en_snap;
    logic [c_idx_w-1:0]         r_idx;
    logic [c_mix_w-1:0]         r_acc;
    logic [c_mix_w-1:0]         r_mix_out;
    logic                       r_mix_valid;
    logic                       r_overrun;
    logic                       w_tick;
    logic [SAMPLE_W-1:0]        w_ch [NUM_CH];
    logic [c_mix_w-1:0]         w_addend;
    logic [c_mix_w-1:0]         w_mix_result;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch[g] = r_snap[g*SAMPLE_W +: SAMPLE_W];
    end

    assign w_tick   = (r_cnt == c_cnt_last);
    assign w_addend = r_en_snap[r_idx] ? {{(c_mix_w-SAMPLE_W){1'b0}}, w_ch[r_idx]}
                                       : '0;

`ifdef MIXER_AVG_EN
    assign w_mix_result = {3'b000, r_acc[10:3]};
`else
    assign w_mix_result = r_acc;
`endif

    // Sample-rate divider runs regardless of FSM state so overruns never skew the rate.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_tick) w_state_nxt = c_st_accum;
            c_st_accum: if (r_idx == c_idx_last) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state != c_st_idle);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_snap      <= '0;
            r_en_snap   <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_tick) begin
                        r_snap    <= audio_bus;
                        r_en_snap <= ch_enable;
                        r_acc     <= '0;
                        r_idx     <= '0;
                    end
                end
                c_st_accum: begin
                    r_acc <= r_acc + w_addend;
                    r_idx <= r_idx + 1'b1;
                end
                c_st_done: begin
                    r_mix_out   <= w_mix_result;
                    r_mix_valid <= 1'b1;
                end
                default: begin
                end
            endcase
            // A tick on the DONE->IDLE edge is also dropped and flagged.
            if (w_tick && (r_state != c_st_idle)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mix_sequencer.sv
`default_nettype none
// Bench for mix_sequencer: two instances (SAMPLE_DIV=16 and 8) against a
// cycle model with a result queue; table vectors plus snapshot/reset sequences.
module tb_mix_sequencer;

    localparam int DIV_A = 16;
    localparam int DIV_B = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] audio_bus = '0;
    logic [7:0]  ch_enable = '0;

    logic [10:0] mix_out_a, mix_out_b;
    logic        mix_valid_a, mix_valid_b;
    logic        busy_a, busy_b;
    logic        overrun_a, overrun_b;

    mix_sequencer #(.SAMPLE_DIV(DIV_A)) dut_a (
        .CLOCK_50(clk), .reset(reset), .audio_bus(audio_bus), .ch_enable(ch_enable),
        .mix_out(mix_out_a), .mix_valid(mix_valid_a), .busy(busy_a), .overrun(overrun_a)
    );

    mix_sequencer #(.SAMPLE_DIV(DIV_B)) dut_b (
        .CLOCK_50(clk), .reset(reset), .audio_bus(audio_bus), .ch_enable(ch_enable),
        .mix_out(mix_out_b), .mix_valid(mix_valid_b), .busy(busy_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chan_sum(input logic [63:0] bus, input logic [7:0] en);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (en[i]) s += int'(bus[i*8 +: 8]);
        end
        return s;
    endfunction

    function automatic int exp_mix(input int s);
`ifdef MIXER_AVG_EN
        return s >> 3;
`else
        return s;
`endif
    endfunction

    // Reference model: index 0 tracks dut_a, index 1 tracks dut_b.
    int m_cnt   [2] = '{0, 0};
    int m_phase [2] = '{0, 0};
    int m_valid [2] = '{0, 0};
    int m_mix   [2] = '{0, 0};
    int m_ovr   [2] = '{0, 0};
    int q0[$];
    int q1[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k]   <= 0;
                m_phase[k] <= 0;
                m_valid[k] <= 0;
                m_mix[k]   <= 0;
                m_ovr[k]   <= 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_cnt[k] == ((k == 0) ? DIV_A : DIV_B) - 1) begin
                    m_cnt[k] <= 0;
                    if (m_phase[k] != 0) m_ovr[k] <= 1;
                end else begin
                    m_cnt[k] <= m_cnt[k] + 1;
                end
                m_valid[k] <= 0;
                if (m_phase[k] == 9) begin
                    m_phase[k] <= 0;
                    m_valid[k] <= 1;
                    if (k == 0) m_mix[k] <= q0.pop_front();
                    else        m_mix[k] <= q1.pop_front();
                end else if (m_phase[k] != 0) begin
                    m_phase[k] <= m_phase[k] + 1;
                end else if (m_cnt[k] == ((k == 0) ? DIV_A : DIV_B) - 1) begin
                    m_phase[k] <= 1;
                    if (k == 0) q0.push_back(exp_mix(chan_sum(audio_bus, ch_enable)));
                    else        q1.push_back(exp_mix(chan_sum(audio_bus, ch_enable)));
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("a_valid",   32'(mix_valid_a), 32'(m_valid[0]));
        chk("a_busy",    32'(busy_a),      32'(m_phase[0] != 0));
        chk("a_overrun", 32'(overrun_a),   32'(m_ovr[0]));
        chk("a_mix",     32'(mix_out_a),   32'(m_mix[0]));
        chk("b_valid",   32'(mix_valid_b), 32'(m_valid[1]));
        chk("b_busy",    32'(busy_b),      32'(m_phase[1] != 0));
        chk("b_overrun", 32'(overrun_b),   32'(m_ovr[1]));
        chk("b_mix",     32'(mix_out_b),   32'(m_mix[1]));
    end

    task automatic wait_valid_a(input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (mix_valid_a) got = 1'b1;
        end
        chk({name, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_phase_a(input int p);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (m_phase[0] == p) got = 1'b1;
        end
        chk("phase_seen", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic [63:0] bus;
        logic [7:0]  en;
        int          sum;
    } vec_t;

    vec_t tv [7];
    int   lat;

    initial begin
        tv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2040};
        tv[1] = '{64'h0807_0605_0403_0201, 8'h55, 16};
        tv[2] = '{64'h0807_0605_0403_0201, 8'h00, 0};
        tv[3] = '{64'h0807_0605_0403_0201, 8'hFF, 36};
        tv[4] = '{64'h1122_3344_5566_7788, 8'hF0, 170};
        tv[5] = '{64'h1122_3344_5566_7788, 8'h0F, 442};
        tv[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 255};

        repeat (3) @(negedge clk);
        chk("rst_mix",     32'(mix_out_a),   32'd0);
        chk("rst_valid",   32'(mix_valid_a), 32'd0);
        chk("rst_busy",    32'(busy_a),      32'd0);
        chk("rst_overrun", 32'(overrun_a),   32'd0);
        #2 reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            audio_bus = tv[i].bus;
            ch_enable = tv[i].en;
            wait_valid_a("tab");
            chk("tab_mix", 32'(mix_out_a), 32'(exp_mix(tv[i].sum)));
        end

        // Snapshot isolation: bus changes after capture must not leak in.
        @(negedge clk);
        audio_bus = 64'h0A0A_0A0A_0A0A_0A0A;
        ch_enable = 8'hFF;
        wait_phase_a(3);
        audio_bus = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_valid_a("snap1");
        chk("snap1_mix", 32'(mix_out_a), 32'(exp_mix(80)));
        wait_valid_a("snap2");
        chk("snap2_mix", 32'(mix_out_a), 32'(exp_mix(2040)));

        chk("a_no_overrun", 32'(overrun_a), 32'd0);
        chk("b_overrun",    32'(overrun_b), 32'd1);

        // Reset mid-accumulation, then first result 16+9 edges after release.
        wait_phase_a(4);
        #2 reset = 1'b1;
        #1;
        chk("mrst_mix",     32'(mix_out_a),   32'd0);
        chk("mrst_valid",   32'(mix_valid_a), 32'd0);
        chk("mrst_busy",    32'(busy_a),      32'd0);
        chk("mrst_overrun", 32'(overrun_b),   32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (mix_valid_a) lat = n;
        end
        chk("mrst_latency", 32'(lat), 32'(DIV_A + 9));
        chk("mrst_result",  32'(mix_out_a), 32'(exp_mix(2040)));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mix_sequencer.md
Name: mix_sequencer

Overview:
- Time-multiplexed sample scheduler for the 8-channel audio mixer.
- Divides CLOCK_50 down to the audio sample rate and snapshots all eight 8-bit channel samples plus the channel-enable mask on each sample tick.
- Accumulates the enabled channels through one shared adder over 8 clocks, then presents the 11-bit mix with a one-cycle valid strobe.
- Sits between the per-channel sample sources and the DAC/audio-codec interface; replaces the parallel adder tree where area matters.

Parameters:
- SAMPLE_DIV, 1134, CLOCK_50 cycles per audio sample (50 MHz / 1134 ≈ 44.1 kHz); legal range >= 2.
- NUM_CH, 8, channel count; fixed at 8 for this revision.
- SAMPLE_W, 8, bits per channel sample.

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- audio_bus  input  64  packed channel samples, unsigned; channel i = audio_bus[8i+7:8i].
- ch_enable  input  8  per-channel enable; bit i gates channel i.
- mix_out  output  11  mixed sample, unsigned.
- mix_valid  output  1  one-cycle strobe; mix_out updated this cycle.
- busy  output  1  high while the FSM is not IDLE.
- overrun  output  1  sticky; a sample tick arrived while busy.

Behaviour:
- Reset (async, active-high): tick counter=0, FSM=IDLE, acc=0, idx=0, snapshot regs=0, mix_out=0, mix_valid=0, busy=0, overrun=0. Reset asserted mid-sequence aborts it; no mix_valid is produced for the aborted sample.
- Tick counter: free-runs 0..SAMPLE_DIV-1, then wraps to 0. tick=1 combinationally while count==SAMPLE_DIV-1. First tick occurs SAMPLE_DIV cycles after reset release.
- FSM states: IDLE, ACCUM, DONE. busy = (state != IDLE).
- IDLE:
  - tick=1 at edge E0: snap <= audio_bus, en_snap <= ch_enable, acc <= 0, idx <= 0, state <= ACCUM.
  - Otherwise hold.
- ACCUM, edges E1..E8: acc <= acc + (en_snap[idx] ? snap[idx] : 0), zero-extended to 11 bits, then idx <= idx+1.
  - At the edge where idx==7: state <= DONE.
- DONE, edge E9: mix_out <= acc; mix_valid <= 1; state <= IDLE.
- mix_valid is high for exactly the one cycle between E9 and E10, then cleared. mix_out holds its value until the next DONE.
- Latency: 9 clock edges from the tick capture edge to mix_out update; sequence occupies 10 cycles including the return to IDLE.
- Arithmetic: maximum sum is 8*255 = 2040, which fits 11 bits, so no overflow or saturation logic is needed.
- Snapshot isolation: changes on audio_bus or ch_enable after E0 have no effect on the in-flight sample.
- Overrun:
  - tick=1 while state != IDLE sets overrun (sticky until reset).
  - That tick is dropped; the current sequence completes unaffected.
  - The tick counter keeps running.
  - Cannot occur when SAMPLE_DIV >= 10.
- A tick coinciding with the DONE->IDLE edge counts as overrun; the sequence does not restart on the same edge.
- ch_enable = 0 on all channels: sequence still runs, and mix_out = 0 with mix_valid pulsed.

Optional Feature:
- Macro: MIXER_AVG_EN.
- When defined: at DONE, mix_out <= {3'b000, acc[10:3]}, i.e. sum divided by 8 (truncated) so the output fits an 8-bit DAC range. Upper 3 bits are always 0.
- When undefined: mix_out is the full 11-bit sum.
- Latency and all handshakes are identical in both builds.

Test Plan:
- Reset mid-ACCUM (SAMPLE_DIV=16, assert reset at E4) -> all outputs 0 immediately; no mix_valid. After release, first mix_valid appears 16+9 edges later.
- All channels 8'hFF, ch_enable=8'hFF, SAMPLE_DIV=16 -> mix_out=2040 (11'h7F8) with mix_valid high exactly one cycle, 9 edges after the tick edge. Repeats every 16 cycles; overrun stays 0.
- Channel i = i+1, ch_enable=8'b0101_0101 -> mix_out = 1+3+5+7 = 16. With ch_enable=8'h00 -> mix_out=0 and mix_valid still pulses.
- All channels 10 at tick, audio_bus driven to 8'hFF on every channel at E3 -> mix_out=80. The following sample yields 2040.
- SAMPLE_DIV=8 -> overrun rises at the first tick during busy and stays 1. mix_valid occurs only for accepted ticks; each accepted result is still correct.
- MIXER_AVG_EN defined, all channels 8'hFF enabled -> mix_out=255. Channels 1..8 all enabled -> mix_out=4 (36>>3).
